// File: rtl/fetch_queue.sv
// Instruction fetch queue: generates sequential fetch addresses, tracks one
// outstanding bus request, buffers responses in a DEPTH-entry FIFO with PC
// and exception status, and handles redirects/flushes.
module fetch_queue #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       fetch_req_o,
    output logic [ADDR_W-1:0]          fetch_addr_o,
    input  logic                       fetch_gnt_i,
    input  logic                       fetch_vld_i,
    input  logic [INSTR_W-1:0]         fetch_instr_i,
    input  logic                       fetch_err_i,
    input  logic                       jmp_en_i,
    input  logic [ADDR_W-1:0]          jmp_to_i,
    output logic                       instr_vld_o,
    output logic [INSTR_W-1:0]         instr_o,
    output logic [ADDR_W-1:0]          pc_o,
    output logic                       except_o,
    output logic [3:0]                 except_cause_o,
    input  logic                       instr_rdy_i,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               exc;
        logic [3:0]         cause;
    } entry_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count;
    entry_t             mem [DEPTH];
    entry_t             head;

    logic flush, mis, req, push, pop;

    assign flush = jmp_en_i;
    assign mis   = (jmp_to_i[1:0] != 2'b00);
    // Request only from IDLE with room; a redirect this cycle suppresses it
    // so no request ever goes out to a soon-to-be-stale (or misaligned) PC.
    assign req   = (state == IDLE) && (count < CNT_W'(DEPTH)) && !jmp_en_i && !rst;
    assign push  = (state == WAIT) && fetch_vld_i && !flush;
    assign pop   = (count != '0) && instr_rdy_i && !flush;

    assign fetch_req_o    = req;
    assign fetch_addr_o   = pc;
    assign head           = mem[rptr];
    assign instr_vld_o    = (count != '0);
    assign instr_o        = head.instr;
    assign pc_o           = head.pc;
    assign except_o       = head.exc;
    assign except_cause_o = head.cause;
    assign count_o        = count;

    // Next-state logic; flush overrides every other event.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            if (mis)
                state_nxt = HALT;
            else if ((state == WAIT || state == DROP) && !fetch_vld_i)
                state_nxt = DROP;
            else
                state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (req && fetch_gnt_i) state_nxt = WAIT;
                WAIT:    if (fetch_vld_i) state_nxt = fetch_err_i ? HALT : IDLE;
                DROP:    if (fetch_vld_i) state_nxt = IDLE;
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register and fetch PC (PC runs one word ahead while in WAIT).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (flush)
                pc <= jmp_to_i;
            else if (req && fetch_gnt_i)
                pc <= pc + ADDR_W'(4);
        end
    end

    // Queue pointers and occupancy; a misaligned redirect leaves one entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= mis ? PTR_W'(1) : '0;
            count <= mis ? CNT_W'(1) : '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Entry storage; the misaligned-target exception lands in slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            if (mis) mem[0] <= '{instr: '0, pc: jmp_to_i, exc: 1'b1, cause: 4'd0};
        end else if (push) begin
            mem[wptr] <= '{instr: fetch_instr_i, pc: pc - ADDR_W'(4),
                           exc: fetch_err_i, cause: 4'd1};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: bus responder plus scoreboard of expected
// queue entries, compared whenever decode pops the head.
module tb_fetch_queue;
    localparam int          ADDR_W   = 64;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic                fetch_req_o;
    logic [ADDR_W-1:0]   fetch_addr_o;
    logic                fetch_gnt_i;
    logic                fetch_vld_i;
    logic [INSTR_W-1:0]  fetch_instr_i;
    logic                fetch_err_i;
    logic                jmp_en_i;
    logic [ADDR_W-1:0]   jmp_to_i;
    logic                instr_vld_o;
    logic [INSTR_W-1:0]  instr_o;
    logic [ADDR_W-1:0]   pc_o;
    logic                except_o;
    logic [3:0]          except_cause_o;
    logic                instr_rdy_i;
    logic [2:0]          count_o;

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o), .fetch_gnt_i(fetch_gnt_i),
        .fetch_vld_i(fetch_vld_i), .fetch_instr_i(fetch_instr_i), .fetch_err_i(fetch_err_i),
        .jmp_en_i(jmp_en_i), .jmp_to_i(jmp_to_i),
        .instr_vld_o(instr_vld_o), .instr_o(instr_o), .pc_o(pc_o), .except_o(except_o),
        .except_cause_o(except_cause_o), .instr_rdy_i(instr_rdy_i), .count_o(count_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc;
        logic [3:0]  cause;
    } ent_t;

    ent_t        sb[$];
    int          errors = 0, checks = 0, grants = 0, pops = 0;
    bit          out_pend = 0, out_stale = 0, err_en = 0;
    logic [63:0] out_addr, exp_pc, err_addr;
    int          out_timer = 0, resp_delay = 1;

    function automatic logic [31:0] mk_instr(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: bus response at negedge, then model/compare, then edge.
    task automatic step();
        ent_t e;
        @(negedge clk);
        fetch_vld_i = 1'b0; fetch_err_i = 1'b0; fetch_instr_i = '0;
        if (rst) begin
            out_pend = 0; sb.delete(); exp_pc = RESET_PC;
        end else if (out_pend) begin
            out_timer--;
            if (out_timer == 0) begin
                fetch_vld_i   = 1'b1;
                fetch_instr_i = mk_instr(out_addr);
                fetch_err_i   = err_en && (out_addr == err_addr);
                out_pend      = 0;
                if (!out_stale && !jmp_en_i) begin
                    e.instr = fetch_instr_i; e.pc = out_addr;
                    e.exc = fetch_err_i; e.cause = 4'd1;
                    sb.push_back(e);
                end
            end
        end
        #1;
        if (rst) begin
            chk("req_in_rst", fetch_req_o, 0);
        end else if (jmp_en_i) begin
            chk("req_in_flush", fetch_req_o, 0);
            sb.delete();
            if (out_pend) out_stale = 1;
            exp_pc = jmp_to_i;
            if (jmp_to_i[1:0] != 2'b00) begin
                e.instr = '0; e.pc = jmp_to_i; e.exc = 1'b1; e.cause = 4'd0;
                sb.push_back(e);
            end
        end else begin
            if (instr_vld_o && instr_rdy_i) begin
                pops++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("head_instr", instr_o, e.instr);
                    chk("head_pc", pc_o, e.pc);
                    chk("head_exc", except_o, e.exc);
                    chk("head_cause", except_cause_o, e.cause);
                end
            end
            if (fetch_req_o && fetch_gnt_i) begin
                chk("fetch_addr", fetch_addr_o, exp_pc);
                out_addr = exp_pc; exp_pc += 64'd4;
                out_pend = 1; out_stale = 0; out_timer = resp_delay;
                grants++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, g;
        rst = 1; fetch_gnt_i = 1; instr_rdy_i = 1; jmp_en_i = 0; jmp_to_i = '0;
        fetch_vld_i = 0; fetch_err_i = 0; fetch_instr_i = '0;
        exp_pc = RESET_PC;
        step(); step();
        chk("rst_req", fetch_req_o, 0);
        chk("rst_addr", fetch_addr_o, RESET_PC);
        chk("rst_vld", instr_vld_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_exc", except_o, 0);
        chk("rst_cause", except_cause_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", pc_o, 0);
        rst = 0; #1;
        chk("req_after_rst", fetch_req_o, 1);

        // Streaming: always grant, 1-cycle responses, decode always ready.
        repeat (16) step();
        chk("stream_grants", grants, 8);
        chk("stream_pops", pops, 7);

        // Fill the queue with decode stalled.
        instr_rdy_i = 0;
        n = 0;
        while (count_o != 3'd4 && n < 20) begin step(); n++; end
        chk("fill_count", count_o, 4);
        g = grants;
        repeat (4) begin step(); chk("req_full", fetch_req_o, 0); end
        chk("full_no_grant", grants, g);
        instr_rdy_i = 1; step(); instr_rdy_i = 0;
        repeat (5) step();
        chk("one_refill_grant", grants, g + 1);
        chk("refill_count", count_o, 4);

        // Redirect while a request is outstanding; late response is stale.
        instr_rdy_i = 1; resp_delay = 3;
        n = 0;
        while (!out_pend && n < 10) begin step(); n++; end
        chk("reached_wait", out_pend, 1);
        jmp_en_i = 1; jmp_to_i = 64'h8000_0100; step(); jmp_en_i = 0;
        resp_delay = 1;
        chk("flush_count", count_o, 0);
        chk("flush_vld", instr_vld_o, 0);
        chk("drop_req_a", fetch_req_o, 0);
        step();
        chk("drop_req_b", fetch_req_o, 0);
        step();
        chk("drop_count", count_o, 0);
        chk("resume_req", fetch_req_o, 1);
        chk("resume_addr", fetch_addr_o, 64'h8000_0100);
        repeat (8) step();

        // Misaligned redirect: exception entry, no request, HALT.
        instr_rdy_i = 0;
        n = 0;
        while (!(count_o == 3'd4 && !out_pend) && n < 20) begin step(); n++; end
        chk("mis_prefill", count_o, 4);
        jmp_en_i = 1; jmp_to_i = 64'h8000_0102; step(); jmp_en_i = 0;
        chk("mis_vld", instr_vld_o, 1);
        chk("mis_exc", except_o, 1);
        chk("mis_cause", except_cause_o, 0);
        chk("mis_pc", pc_o, 64'h8000_0102);
        chk("mis_count", count_o, 1);
        g = grants;
        repeat (4) begin step(); chk("req_halt", fetch_req_o, 0); end
        instr_rdy_i = 1;
        repeat (4) step();
        chk("halt_no_grant", grants, g);
        chk("halt_count", count_o, 0);

        // Access fault at 0x8000_0008 stops fetching until the next redirect.
        err_en = 1; err_addr = 64'h8000_0008;
        jmp_en_i = 1; jmp_to_i = 64'h8000_0000; step(); jmp_en_i = 0;
        g = grants;
        repeat (12) step();
        chk("err_grants", grants, g + 3);
        chk("err_req", fetch_req_o, 0);
        chk("err_drained", sb.size(), 0);
        err_en = 0;
        jmp_en_i = 1; jmp_to_i = 64'h8000_0000; step(); jmp_en_i = 0;
        g = grants;
        repeat (6) step();
        chk("err_resume", grants, g + 3);

        // Reset mid-operation with three entries queued and a request in flight.
        instr_rdy_i = 0;
        n = 0;
        while (!(count_o == 3'd3 && out_pend) && n < 20) begin step(); n++; end
        chk("pre_rst_count", count_o, 3);
        rst = 1; step(); rst = 0;
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_vld", instr_vld_o, 0);
        chk("mid_rst_addr", fetch_addr_o, RESET_PC);
        instr_rdy_i = 1;
        g = grants;
        repeat (6) step();
        chk("post_rst_grants", grants, g + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue between the instruction-fetch bus port and the decode stage of the pipeline core. It replaces the single-entry IF path with a DEPTH-entry FIFO that carries instruction, PC and fetch exception status. It generates sequential fetch addresses itself, redirects on jumps, discards stale in-flight responses, and reports misaligned-target and access-fault exceptions in order with instructions.

## Interface
- ADDR_W, 64, PC / fetch address width
- INSTR_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 64'h8000_0000, first fetch address after reset (bits[1:0] = 0)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- fetch_req_o  out  1  fetch request valid
- fetch_addr_o  out  ADDR_W  fetch address (= internal PC)
- fetch_gnt_i  in  1  request accepted this cycle
- fetch_vld_i  in  1  response valid
- fetch_instr_i  in  INSTR_W  response instruction
- fetch_err_i  in  1  response access fault (qualified by fetch_vld_i)
- jmp_en_i  in  1  redirect / flush
- jmp_to_i  in  ADDR_W  redirect target
- instr_vld_o  out  1  head entry valid
- instr_o  out  INSTR_W  head instruction
- pc_o  out  ADDR_W  head PC
- except_o  out  1  head entry is an exception
- except_cause_o  out  4  4'd0 = instr addr misaligned, 4'd1 = instr access fault
- instr_rdy_i  in  1  decode consumes head when instr_vld_o & instr_rdy_i
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: DEPTH-entry circular buffer with {instr, pc, except, cause}. Write/read pointers wrap modulo DEPTH. Count is tracked separately so full and empty are distinct.
- FSM states:
  - IDLE: no request outstanding. fetch_req_o = (count_o < DEPTH) & ~jmp_en_i. On fetch_req_o & fetch_gnt_i: go to WAIT, PC += 4 (wraps modulo 2^ADDR_W).
  - WAIT: one request outstanding, fetch_req_o = 0. On fetch_vld_i: push {fetch_instr_i, PC−4, fetch_err_i, 4'd1}. Go to HALT if fetch_err_i, else IDLE.
  - DROP: an outstanding response is stale. On fetch_vld_i: discard the response and go to IDLE.
  - HALT: exception entry queued; no requests. Leave only on jmp_en_i.
- Overflow is impossible by construction:
  - A request is issued only when count_o < DEPTH, and only one request is outstanding.
  - A pop in the same cycle as the push is allowed.
- Flush (jmp_en_i = 1), highest priority over all other events in that cycle:
  - Queue cleared (count 0, pointers 0). A coincident push or pop has no effect.
  - PC <= jmp_to_i.
  - Next state:
    - WAIT without fetch_vld_i this cycle → DROP.
    - WAIT with fetch_vld_i this cycle → IDLE (response discarded).
    - DROP → DROP, unless fetch_vld_i this cycle, in which case IDLE.
    - IDLE or HALT → IDLE.
  - If jmp_to_i[1:0] != 0: push one entry {instr 0, pc jmp_to_i, except 1, cause 4'd0} the next cycle and enter HALT. No bus request is ever made to a misaligned address.
- Simultaneous push and pop with count unchanged: both pointers advance.
- Output data (instr_o, pc_o, except_o, except_cause_o) is don't-care when instr_vld_o = 0.

## Timing
- Reset values:
  - fetch_req_o 0 during rst, then 1 in the first cycle after rst deasserts.
  - fetch_addr_o = RESET_PC.
  - instr_vld_o 0, count_o 0, except_o 0, except_cause_o 0, instr_o 0, pc_o 0, state IDLE.
- rst asserted mid-operation: all state returns to reset values at the next edge. Any in-flight response is not tracked; the bus side is reset together with the queue.
- Latency:
  - Response push is visible at instr_vld_o the cycle after fetch_vld_i, since outputs come from registers.
  - Best-case throughput is one instruction per 2 cycles (request + response).
- fetch_req_o and fetch_addr_o hold stable until fetch_gnt_i.
- instr_vld_o, instr_o, pc_o, except_o and except_cause_o are registered/RAM-read outputs. Their only combinational input is the pointer state.
- Misaligned-redirect entry: instr_vld_o = 1 one cycle after the flush cycle.

## Test plan
- Reset release, always-grant bus, 1-cycle responses, instr_rdy_i = 1 → requests at 0x8000_0000, _0004, _0008…; pc_o matches each instr_o in order.
- instr_rdy_i = 0 with DEPTH = 4 → count_o reaches 4, fetch_req_o stays 0; one pop → exactly one new request, count_o returns to 4.
- jmp_en_i with jmp_to_i = 0x8000_0100 while in WAIT, response arrives 2 cycles later → response dropped, count_o 0, next request at 0x8000_0100.
- jmp_en_i with jmp_to_i = 0x8000_0102 → no request issued; head entry has except_o = 1, cause 0, pc_o 0x8000_0102; stays in HALT until the next jmp_en_i.
- Response with fetch_err_i = 1 at 0x8000_0008 → entry with except_o = 1, cause 1; no further requests; a subsequent flush to 0x8000_0000 resumes fetching.
- rst pulsed while count_o = 3 and in WAIT → next cycle count_o 0, instr_vld_o 0, fetch_addr_o = RESET_PC.
